// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and helpers for the fifo write arbiter: FSM states and record header format.
// Header word layout: bits [7:4] carry the sync marker, bits [3:0] carry the source id.
package fifo_write_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_HEADER,
    ARB_PAYLOAD
  } arb_state_t;

  localparam logic [3:0] HEADER_SYNC_DEFAULT = 4'hA;
  localparam int         HEADER_WIDTH        = 8;

  function automatic logic [HEADER_WIDTH-1:0] make_header(input logic [3:0] sync,
                                                           input logic [3:0] id);
    return {sync, id};
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Capture-source handshakes, fifo_buffer write side and status of the write arbiter.
// master = arbiter side, slave = sources plus fifo_buffer.
interface fifo_write_arbiter_if #(
  parameter int NUM_REQUESTERS = 4,
  parameter int DATA_WIDTH     = 8
);
  localparam int ID_WIDTH = $clog2(NUM_REQUESTERS);

  logic [NUM_REQUESTERS-1:0]            req_valid;
  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQUESTERS-1:0]            req_ready;
  logic                                 fifo_full;
  logic                                 fifo_write_enable;
  logic [DATA_WIDTH-1:0]                fifo_write_data;
  logic [ID_WIDTH-1:0]                  grant_id;
  logic                                 busy;

  modport master (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_write_enable, fifo_write_data, grant_id, busy
  );

  modport slave (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_write_enable, fifo_write_data, grant_id, busy
  );

endinterface

// File: rtl/fifo_write_arbiter_round_robin_picker.sv
// Combinational round-robin search: first set valid bit after last_i, wrapping modulo N.
// Works for any N >= 2, power of two or not.
module round_robin_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         valid_i,
  input  logic [$clog2(N)-1:0] last_i,
  output logic                 found_o,
  output logic [$clog2(N)-1:0] index_o
);

  localparam int IW = $clog2(N);

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= N) sum = sum - N;
    return IW'(sum);
  endfunction

  logic [IW-1:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest valid one wins.
  always_comb begin
    found_o = 1'b0;
    index_o = '0;
    cand    = '0;
    for (int k = N; k >= 1; k--) begin
      cand = wrap_add(last_i, k);
      if (valid_i[cand]) begin
        found_o = 1'b1;
        index_o = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter turning each accepted source sample into a {header, payload} FIFO record.
// Header 1 cycle after accept, payload next; fifo_full stalls either word, never drops a sample.
module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter int         NUM_REQUESTERS = 4,
  parameter int         DATA_WIDTH     = 8,
  parameter logic [3:0] HEADER_SYNC    = HEADER_SYNC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_write_arbiter_if.master bus
);

  localparam int IW = $clog2(NUM_REQUESTERS);

  arb_state_t            state_q, state_d;
  logic [IW-1:0]         last_q, last_d;
  logic [IW-1:0]         id_q, id_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic                      pick_found;
  logic [IW-1:0]             pick_idx;
  logic [NUM_REQUESTERS-1:0] ready;
  logic                      wr_en;
  logic [DATA_WIDTH-1:0]     wr_data;

  round_robin_picker #(.N(NUM_REQUESTERS)) u_picker (
    .valid_i (bus.req_valid),
    .last_i  (last_q),
    .found_o (pick_found),
    .index_o (pick_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      last_q  <= IW'(NUM_REQUESTERS - 1);
      id_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    data_d  = data_q;
    ready   = '0;
    wr_en   = 1'b0;
    wr_data = '0;

    unique case (state_q)
      ARB_IDLE: begin
        // Gated by reset so no source sees a combinational ready while reset is held.
        if (reset && pick_found && !bus.fifo_full) begin
          ready[pick_idx] = 1'b1;
          id_d            = pick_idx;
          for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (pick_idx == IW'(i)) data_d = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
          end
          state_d = ARB_HEADER;
        end
      end

      ARB_HEADER: begin
        if (!bus.fifo_full) begin
          wr_en                     = 1'b1;
          wr_data[HEADER_WIDTH-1:0] = make_header(HEADER_SYNC, 4'(id_q));
          state_d                   = ARB_PAYLOAD;
        end
      end

      ARB_PAYLOAD: begin
        if (!bus.fifo_full) begin
          wr_en   = 1'b1;
          wr_data = data_q;
          last_d  = id_q;
          state_d = ARB_IDLE;
        end
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  assign bus.req_ready         = ready;
  assign bus.fifo_write_enable = wr_en;
  assign bus.fifo_write_data   = wr_data;
  assign bus.grant_id          = id_q;
  assign bus.busy              = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: vector table, directed corner sequences, then random traffic
// checked against a queue-based record model.
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic clk;
  logic reset;

  fifo_write_arbiter_if #(.NUM_REQUESTERS(N), .DATA_WIDTH(DW)) bus ();

  fifo_write_arbiter #(.NUM_REQUESTERS(N), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic        full;
    logic [3:0]  exp_ready;
    logic        exp_we;
    logic [7:0]  exp_wd;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[$];

  typedef struct {
    logic [7:0] word;
    int         id;
    bit         is_payload;
  } ent_t;

  ent_t model_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic f);
    @(posedge clk);
    #1;
    bus.req_valid = v;
    bus.req_data  = d;
    bus.fifo_full = f;
    @(negedge clk);
  endtask

  task automatic chk_out(input string name, input logic [3:0] rdy, input logic we,
                         input logic [7:0] wd, input logic bsy);
    chk({name, ".ready"}, 32'(bus.req_ready), 32'(rdy));
    chk({name, ".we"},    32'(bus.fifo_write_enable), 32'(we));
    chk({name, ".wdata"}, 32'(bus.fifo_write_data), 32'(wd));
    chk({name, ".busy"},  32'(bus.busy), 32'(bsy));
  endtask

  // One record = accept row, header row, payload row; valid_rest holds during the record.
  task automatic add_rec(input logic [3:0] v, input logic [31:0] d, input int g,
                         input logic [7:0] payload, input logic [3:0] valid_rest);
    logic [3:0] onehot;
    onehot = 4'b0001 << g;
    vecs.push_back('{v, d, 1'b0, onehot, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{valid_rest, d, 1'b0, 4'b0000, 1'b1, 8'hA0 | 8'(g), 1'b1});
    vecs.push_back('{valid_rest, d, 1'b0, 4'b0000, 1'b1, payload, 1'b1});
  endtask

  function automatic int rr_pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  rv;
    logic [31:0] rd;
    logic        rf;
    logic [3:0]  acc_prev;
    logic [3:0]  exp_rdy;
    logic        exp_we;
    int          model_last;
    int          w;

    reset         = 1'b0;
    bus.req_valid = 4'hF;
    bus.req_data  = 32'h13121110;
    bus.fifo_full = 1'b0;

    // Reset held with every source requesting.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_out("reset", 4'b0000, 1'b0, 8'h00, 1'b0);
    chk("reset.grant_id", 32'(bus.grant_id), 32'h0);
    @(posedge clk);
    #1;
    reset         = 1'b1;
    bus.req_valid = 4'h0;

    // Round robin from last_grant=3, then single source, wrap and skip.
    for (int r = 0; r < 5; r++) add_rec(4'hF, 32'h13121110, r % N, 8'h10 + 8'(r % N), 4'hF);
    add_rec(4'b0100, 32'h005C0000, 2, 8'h5C, 4'b0000);
    vecs.push_back('{4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0});
    add_rec(4'b1000, 32'h77000000, 3, 8'h77, 4'b0000);
    add_rec(4'b0010, 32'h00002100, 1, 8'h21, 4'b0000);
    add_rec(4'b0011, 32'h00003130, 0, 8'h30, 4'b0010);
    add_rec(4'b0010, 32'h00003130, 1, 8'h31, 4'b0000);

    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].data, vecs[i].full);
      chk_out($sformatf("vec%0d", i), vecs[i].exp_ready, vecs[i].exp_we,
              vecs[i].exp_wd, vecs[i].exp_busy);
    end

    // Back-pressure: 5-cycle stall in HEADER, 1-cycle stall in PAYLOAD, full in IDLE.
    drive(4'b0001, 32'h0000554B, 1'b0);
    chk_out("bp.accept", 4'b0001, 1'b0, 8'h00, 1'b0);
    for (int s = 0; s < 5; s++) begin
      drive(4'b0010, 32'h0000554B, 1'b1);
      chk_out($sformatf("bp.hstall%0d", s), 4'b0000, 1'b0, 8'h00, 1'b1);
      chk("bp.grant_id", 32'(bus.grant_id), 32'h0);
    end
    drive(4'b0010, 32'h0000554B, 1'b0);
    chk_out("bp.header", 4'b0000, 1'b1, 8'hA0, 1'b1);
    drive(4'b0010, 32'h0000554B, 1'b1);
    chk_out("bp.pstall", 4'b0000, 1'b0, 8'h00, 1'b1);
    drive(4'b0010, 32'h0000554B, 1'b0);
    chk_out("bp.payload", 4'b0000, 1'b1, 8'h4B, 1'b1);
    drive(4'b0010, 32'h0000554B, 1'b1);
    chk_out("bp.idle_full", 4'b0000, 1'b0, 8'h00, 1'b0);
    drive(4'b0010, 32'h0000554B, 1'b0);
    chk_out("bp.next", 4'b0010, 1'b0, 8'h00, 1'b0);
    drive(4'b0000, 32'h0, 1'b0);
    chk_out("bp.next_hdr", 4'b0000, 1'b1, 8'hA1, 1'b1);
    drive(4'b0000, 32'h0, 1'b0);
    chk_out("bp.next_pay", 4'b0000, 1'b1, 8'h55, 1'b1);

    // Reset mid-record: asserted during PAYLOAD.
    drive(4'b0100, 32'h00660000, 1'b0);
    chk_out("rst.accept", 4'b0100, 1'b0, 8'h00, 1'b0);
    drive(4'b0000, 32'h00660000, 1'b0);
    chk_out("rst.header", 4'b0000, 1'b1, 8'hA2, 1'b1);
    @(posedge clk);
    #1;
    reset         = 1'b0;
    bus.req_valid = 4'hF;
    bus.req_data  = 32'h13121110;
    @(negedge clk);
    chk_out("rst.mid", 4'b0000, 1'b0, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk_out("rst.regrant", 4'b0001, 1'b0, 8'h00, 1'b0);
    drive(4'b0000, 32'h13121110, 1'b0);
    chk_out("rst.hdr", 4'b0000, 1'b1, 8'hA0, 1'b1);
    drive(4'b0000, 32'h13121110, 1'b0);
    chk_out("rst.pay", 4'b0000, 1'b1, 8'h10, 1'b1);

    // Random traffic against the record model, starting from a fresh reset.
    @(posedge clk);
    #1;
    reset         = 1'b0;
    bus.req_valid = 4'h0;
    @(posedge clk);
    #1;
    reset      = 1'b1;
    model_last = N - 1;
    acc_prev   = 4'h0;
    rv         = 4'h0;
    rd         = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc_prev[i]) begin
          rv[i] = 1'b0;
        end else if (!rv[i] && ($urandom % 3 == 0)) begin
          rv[i]           = 1'b1;
          rd[i*DW +: DW] = 8'($urandom);
        end else if (rv[i] && ($urandom % 20 == 0)) begin
          rv[i] = 1'b0;
        end
      end
      rf            = ($urandom % 4 == 0);
      bus.req_valid = rv;
      bus.req_data  = rd;
      bus.fifo_full = rf;
      @(negedge clk);

      exp_rdy = 4'h0;
      if (model_q.size() == 0 && !rf && rv != 4'h0) begin
        w       = rr_pick(rv, model_last);
        exp_rdy = 4'b0001 << w;
      end
      exp_we = (model_q.size() != 0) && !rf;
      chk("rnd.ready", 32'(bus.req_ready), 32'(exp_rdy));
      chk("rnd.we", 32'(bus.fifo_write_enable), 32'(exp_we));
      chk("rnd.busy", 32'(bus.busy), 32'(model_q.size() != 0));
      if (exp_we) chk("rnd.wdata", 32'(bus.fifo_write_data), 32'(model_q[0].word));
      else        chk("rnd.wdata_idle", 32'(bus.fifo_write_data), 32'h0);
      if (model_q.size() != 0) chk("rnd.grant_id", 32'(bus.grant_id), 32'(model_q[0].id));

      if (exp_we) begin
        if (model_q[0].is_payload) model_last = model_q[0].id;
        void'(model_q.pop_front());
      end
      if (exp_rdy != 4'h0) begin
        model_q.push_back('{8'hA0 | 8'(w), w, 1'b0});
        model_q.push_back('{rd[w*DW +: DW], w, 1'b1});
      end
      acc_prev = exp_rdy;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
